// File: rtl/uni_reg_pkg.sv
// Shared definitions for the universal shift register and its controllers:
// register opcodes and the serializer FSM state encoding.
package uni_reg_pkg;
  localparam logic [1:0] DO_NOTHING    = 2'b00;
  localparam logic [1:0] SHIFT_LEFT    = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT   = 2'b10;
  localparam logic [1:0] PARALLEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;
endpackage

// File: rtl/uni_reg_bit_cnt.sv
// Terminal-count bit counter: synchronous clear, enable, saturates at N-1
// and flags the last index.
module uni_reg_bit_cnt #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(N)-1:0] o_cnt,
  output logic                 o_last
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_en && !o_last) r_cnt <= r_cnt + CW'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST);
endmodule

// File: rtl/uni_reg_ser_ctrl.sv
// Parallel-to-serial sequencer for the universal shift register: load, then
// N-1 right shifts, flagging each valid s_out bit. Optional gapless streaming
// with one pre-accepted word is enabled by UNI_REG_SER_CTRL_STREAM_EN.
module uni_reg_ser_ctrl
  import uni_reg_pkg::*;
#(
  parameter int   N    = 8,
  parameter logic FILL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [N-1:0]         in_data,
  output logic                 in_ready,
  output logic [1:0]           data_ctrl,
  output logic [N-1:0]         p_load,
  output logic                 s_fill,
  output logic                 bit_valid,
  output logic [$clog2(N)-1:0] bit_idx,
  output logic                 word_done,
  output logic                 busy
);
  state_e               r_state, w_next;
  logic [N-1:0]         r_hold;
  logic [$clog2(N)-1:0] w_cnt;
  logic                 w_last, w_cnt_clr, w_cnt_en, w_xfer, w_reload;

`ifdef UNI_REG_SER_CTRL_STREAM_EN
  logic r_pend;

  // The last-bit cycle frees hold (its word is loaded now), so a new word may
  // land in hold on the same edge.
  assign in_ready = reset_n && ((r_state == IDLE) ||
                    ((r_state == SHIFT) && (!r_pend || w_last)));
  assign w_reload = (r_state == SHIFT) && w_last && r_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_pend <= 1'b0;
    else if (w_xfer)                        r_pend <= 1'b1;
    else if ((r_state == LOAD) || w_reload) r_pend <= 1'b0;
  end
`else
  assign in_ready = reset_n && (r_state == IDLE);
  assign w_reload = 1'b0;
`endif

  assign w_xfer = in_valid && in_ready;

  uni_reg_bit_cnt #(.N(N)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) r_hold <= in_data;
    end
  end

  always_comb begin
    w_next    = r_state;
    data_ctrl = DO_NOTHING;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      IDLE: if (w_xfer) w_next = LOAD;
      LOAD: begin
        data_ctrl = PARALLEL_LOAD;
        w_cnt_clr = 1'b1;
        w_next    = SHIFT;
      end
      SHIFT: begin
        if (!w_last) begin
          data_ctrl = SHIFT_RIGHT;
          w_cnt_en  = 1'b1;
        end else if (w_reload) begin
          data_ctrl = PARALLEL_LOAD;
          w_cnt_clr = 1'b1;
        end else if (w_xfer) begin
          // streaming only: word arrived on the last bit with nothing pending
          w_next = LOAD;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign p_load    = r_hold;
  assign s_fill    = FILL;
  assign busy      = (r_state != IDLE);
  assign bit_valid = (r_state == SHIFT);
  assign bit_idx   = bit_valid ? w_cnt : '0;
  assign word_done = bit_valid && w_last;
endmodule

// File: tb/tb_uni_reg_ser_ctrl.sv
// Bench: serializer driving a behavioural universal shift register (N=8), plus
// a second N=2/FILL=1 instance; serial bits are checked against a scoreboard.
module tb_uni_reg_ser_ctrl;
  localparam int N = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [N-1:0] in_data  = '0;
  logic         in_ready, s_fill, bit_valid, word_done, busy;
  logic [1:0]   data_ctrl;
  logic [N-1:0] p_load, q;
  logic [2:0]   bit_idx;
  logic         s_out;

  logic       in_valid2 = 1'b0;
  logic [1:0] in_data2  = '0;
  logic       in_ready2, s_fill2, bit_valid2, word_done2, busy2;
  logic [1:0] dc2, p_load2, q2;
  logic [0:0] bit_idx2;

  uni_reg_ser_ctrl #(.N(N), .FILL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_ctrl(data_ctrl), .p_load(p_load), .s_fill(s_fill),
    .bit_valid(bit_valid), .bit_idx(bit_idx), .word_done(word_done), .busy(busy));

  uni_reg_ser_ctrl #(.N(2), .FILL(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .data_ctrl(dc2), .p_load(p_load2), .s_fill(s_fill2),
    .bit_valid(bit_valid2), .bit_idx(bit_idx2), .word_done(word_done2), .busy(busy2));

  // behavioural universal shift registers sharing the reset net
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else case (data_ctrl)
      2'b11: q <= p_load;
      2'b10: q <= {s_fill, q[N-1:1]};
      2'b01: q <= {q[N-2:0], s_fill};
      default: q <= q;
    endcase
  end
  assign s_out = q[0];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) q2 <= '0;
    else case (dc2)
      2'b11: q2 <= p_load2;
      2'b10: q2 <= {s_fill2, q2[1]};
      2'b01: q2 <= {q2[0], s_fill2};
      default: q2 <= q2;
    endcase
  end

  int n_chk = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic b; int idx; } sb_t;
  sb_t sbq[$];
  int  t0q[$], vq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("no_left", data_ctrl == 2'b01, 0);
      if (bit_valid) begin
        vq.push_back(cyc);
        if (bit_idx == 3'd0) t0q.push_back(cyc);
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          sb_t e;
          e = sbq.pop_front();
          chk("s_out", s_out, e.b);
          chk("bit_idx", bit_idx, e.idx);
          chk("word_done", word_done, e.idx == N-1);
        end
      end else begin
        chk("word_done_idle", word_done, 0);
      end
    end
  end

  task automatic send(input logic [N-1:0] w);
    logic acc;
    int   n;
    in_valid = 1'b1; in_data = w; acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); n++;
    end
    chk("send_accept", acc, 1);
    for (int k = 0; k < N; k++) sbq.push_back('{b: w[k], idx: k});
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || sbq.size() != 0) && n < 100);
    chk("idle_timeout", n < 100, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dc", data_ctrl, 0);
    chk("rst_p_load", p_load, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_busy", busy, 0);
    chk("s_fill", s_fill, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      chk("idle_dc", data_ctrl, 0);
      chk("idle_busy", busy, 0);
    end

    // single word 8'hA5 with opcode sequence
    @(posedge clk); #1;
    send(8'hA5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("a5_load_dc", data_ctrl, 2'b11);
    chk("a5_load_ready", in_ready, 0);
    chk("a5_p_load", p_load, 8'hA5);
    chk("a5_busy", busy, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("a5_shift_dc", data_ctrl, 2'b10);
`ifdef UNI_REG_SER_CTRL_STREAM_EN
      if (i == 0) chk("a5_ready_shift", in_ready, 1);
`else
      if (i == 0) chk("a5_ready_shift", in_ready, 0);
`endif
    end
    @(negedge clk);
    chk("a5_last_dc", data_ctrl, 2'b00);
    chk("a5_word_done", word_done, 1);
    wait_idle();

    // back-to-back words with in_valid held high
    t0q.delete(); vq.delete();
    @(posedge clk); #1;
    send(8'h01);
    send(8'h80);
    in_valid = 1'b0;
    wait_idle();
`ifdef UNI_REG_SER_CTRL_STREAM_EN
    chk("b2b_gap", t0q.size() >= 2 ? t0q[1] - t0q[0] : 0, 8);
    chk("b2b_span", vq.size() >= 16 ? vq[15] - vq[0] : 0, 15);
`else
    chk("b2b_gap", t0q.size() >= 2 ? t0q[1] - t0q[0] : 0, 10);
    chk("b2b_span", vq.size() >= 16 ? vq[15] - vq[0] : 0, 17);
`endif

    // in_data changes after acceptance must not leak in
    @(posedge clk); #1;
    send(8'h3C);
    in_valid = 1'b0; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("3c_p_load", p_load, 8'h3C);
    wait_idle();

    // reset during bit 4 of 8'hF0
    @(posedge clk); #1;
    send(8'hF0);
    in_valid = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(bit_valid && bit_idx == 3'd4) && n < 50);
      chk("f0_reach_bit4", n < 50, 1);
    end
    #1 reset_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_rst_dc", data_ctrl, 0);
    chk("mid_rst_p_load", p_load, 0);
    chk("mid_rst_bit_valid", bit_valid, 0);
    chk("mid_rst_bit_idx", bit_idx, 0);
    chk("mid_rst_word_done", word_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_q", q, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h0F);
    in_valid = 1'b0;
    wait_idle();
    chk("0f_q_after", q, 8'h00);

    // N=2, FILL=1 instance
    @(posedge clk); #1;
    in_valid2 = 1'b1; in_data2 = 2'b10;
    @(negedge clk);
    chk("n2_ready", in_ready2, 1);
    chk("n2_s_fill", s_fill2, 1);
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("n2_load_dc", dc2, 2'b11);
    @(negedge clk);
    chk("n2_b0_valid", bit_valid2, 1);
    chk("n2_b0_idx", bit_idx2, 0);
    chk("n2_b0", q2[0], 0);
    chk("n2_b0_done", word_done2, 0);
    @(negedge clk);
    chk("n2_b1_valid", bit_valid2, 1);
    chk("n2_b1_idx", bit_idx2, 1);
    chk("n2_b1", q2[0], 1);
    chk("n2_b1_done", word_done2, 1);
    chk("n2_b1_dc", dc2, 2'b00);
    @(negedge clk);
    chk("n2_q_final", q2, 2'b11);
    chk("n2_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/uni_reg_ser_ctrl.md
# uni_reg_ser_ctrl

Upstream sequencer for the universal shift register in parallel-to-serial mode. Accepts N-bit words over a valid/ready handshake and drives the register's `data_ctrl`, `p_in` and `s_in` inputs: one parallel load, then N-1 right shifts. It also flags each cycle on which the register's `s_out` holds a valid data bit, so a downstream consumer can sample the LSB-first serial stream.

## Interface
- `N`, default 8: word width; must match the driven register. N ≥ 2.
- `FILL`, default 1'b0: constant driven on `s_in` during shifts.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  N  upstream word.
- `in_ready`  out  1  block can accept a word; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `data_ctrl`  out  2  register opcode: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- `p_load`  out  N  word presented to the register's `p_in`.
- `s_fill`  out  1  drives the register's `s_in`; always equals `FILL`.
- `bit_valid`  out  1  register `s_out` holds data bit `bit_idx` during this cycle.
- `bit_idx`  out  $clog2(N)  index of the bit currently on `s_out`.
- `word_done`  out  1  single-cycle pulse on the cycle the last bit (index N-1) is valid.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `data_ctrl`=00. On transfer, capture `in_data` into `hold` and go to LOAD.
  - LOAD: `data_ctrl`=11, `p_load`=`hold`. Go to SHIFT with `cnt`=0.
  - SHIFT: `bit_valid`=1, `bit_idx`=`cnt`.
    - If `cnt`<N-1: `data_ctrl`=10, `cnt`++.
    - If `cnt`==N-1: `word_done`=1 and go to IDLE. `data_ctrl`=00, unless overridden by the configured streaming feature.
- `p_load` equals `hold` in every state. `hold` changes only on a transfer.
- `cnt` is $clog2(N) bits wide. It never wraps past N-1, and it is cleared on entry to SHIFT.
- `data_ctrl`=01 is never issued.
- Reset mid-operation:
  - All state clears immediately and the word in flight is discarded.
  - The register is reset by the same reset net.
- Reset values:
  - State IDLE, `cnt`=0, `hold`=0.
  - `data_ctrl`=00, `p_load`=0, `bit_valid`=0, `bit_idx`=0, `word_done`=0, `busy`=0.
  - `in_ready` is forced to 0 while `reset_n` is low.

## Timing
- Transfer at edge T. LOAD occupies cycle T+1. The register holds the word after edge T+2.
- Bit k is valid on `s_out` in cycle T+2+k, with `bit_valid`=1 and `bit_idx`=k.
- `word_done` is asserted in cycle T+1+N.
- Base throughput: one word per N+2 cycles, because IDLE always takes at least one cycle.
- `in_ready` depends only on state and `hold` occupancy. There is no combinational path from `in_valid` to `in_ready`.
- `in_data` is sampled only at the transfer edge; later changes have no effect.

## Configuration
- `UNI_REG_SER_CTRL_STREAM_EN` defined: gapless streaming.
  - In SHIFT, `in_ready`=1 while `hold` holds no pending word, so one word can be pre-accepted into `hold`.
  - At `cnt`==N-1 with a pending word: drive `data_ctrl`=11 instead of 00, stay in SHIFT, and set `cnt` to 0. The next word's bit 0 is valid in the very next cycle.
  - Throughput is then one word per N cycles, and `bit_valid` stays high continuously.
  - A transfer and the last-bit load in the same cycle are legal: the incoming word is captured into `hold` after the current pending word has been loaded.
- Not defined: `in_ready` is high only in IDLE; base behaviour above.

## Structure
- Shared package `uni_reg_pkg`:
  - Opcode constants DO_NOTHING=2'b00, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, PARALLEL_LOAD=2'b11.
  - The FSM state encoding IDLE/LOAD/SHIFT.
- One sub-module, `uni_reg_bit_cnt`: a terminal-count bit counter with clear, enable and a `last` flag at N-1.
- Bench instantiates this block driving `uni_reg` with N=8.

## Test plan
- Reset release, no input: `in_ready`=1 and `data_ctrl`=00 hold for 20 cycles; `busy`=0.
- Send 8'hA5 at edge T: `data_ctrl`=11 in T+1, then 10 for seven cycles, then 00. `s_out` sequence over T+2..T+9 is 1,0,1,0,0,1,0,1. `word_done` is high in T+9.
- Keep `in_valid` high with 8'h01 then 8'h80:
  - Base build: second bit 0 appears 10 cycles after the first.
  - `UNI_REG_SER_CTRL_STREAM_EN` build: second bit 0 appears exactly 8 cycles after the first, and `bit_valid` has no gap.
- Change `in_data` to 8'hFF one cycle after accepting 8'h3C: serial output is still 0,0,1,1,1,1,0,0.
- Assert `reset_n` low during bit 4 of 8'hF0: outputs go to reset values immediately, the register reads 0, and after release the next word 8'h0F serializes correctly.
- N=2, FILL=1, send 2'b10: bits 0,1 appear, and the register reads 2'b11 after one further shift-free cycle.
